// File: rtl/vc_ctrl_param.sv
// Victim-cache controller: way selection, age-based LRU, demand write-back of dirty victims
// and idle-time scrubbing of dirty entries. Drives datapath strobes only.
module vc_ctrl_param #(
    parameter int unsigned NUM_WAYS    = 8,
    parameter int unsigned WAY_W       = $clog2(NUM_WAYS),
    parameter int unsigned IDLE_THRESH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                l2_read,
    input  logic                l2_write,
    input  logic                l2_dirty,
    input  logic                hit,
    input  logic [WAY_W-1:0]    hit_way,
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic [NUM_WAYS-1:0] dirty_vec,
    input  logic                mem_ack,
    output logic                vc_ack,
    output logic                vc_miss,
    output logic                busy,
    output logic                load_data,
    output logic                load_dirty,
    output logic                dirty_in,
    output logic [WAY_W-1:0]    data_way,
    output logic                mem_write_req,
    output logic [WAY_W-1:0]    mem_way,
    output logic [WAY_W-1:0]    lru_way
);

    typedef enum logic [1:0] {StIdle, StDemandWb, StScrubWb} state_e;

    state_e            state_q, state_d;
    logic [WAY_W-1:0]  mem_way_q, mem_way_d;
    logic [7:0]        idle_cnt_q, idle_cnt_d;
    logic [WAY_W-1:0]  age_q [NUM_WAYS];
    logic [WAY_W-1:0]  age_d [NUM_WAYS];

    logic              touch_en;
    logic [WAY_W-1:0]  touch_way;
    logic [WAY_W-1:0]  victim;
    logic              found_inv;
    logic [WAY_W-1:0]  max_age;
    logic              scrub_any;
    logic [WAY_W-1:0]  scrub_way;
    logic [NUM_WAYS-1:0] scrub_vec;

    assign scrub_vec = valid_vec & dirty_vec;
    assign lru_way   = victim;
    assign mem_way   = mem_way_q;

    // Lowest invalid way wins; otherwise the oldest way (lowest index on a tie).
    always_comb begin
        victim    = '0;
        found_inv = 1'b0;
        max_age   = age_q[0];
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!found_inv && !valid_vec[i]) begin
                found_inv = 1'b1;
                victim    = WAY_W'(i);
            end
        end
        if (!found_inv) begin
            for (int i = 1; i < NUM_WAYS; i++) begin
                if (age_q[i] > max_age) begin
                    max_age = age_q[i];
                    victim  = WAY_W'(i);
                end
            end
        end
    end

    always_comb begin
        scrub_any = 1'b0;
        scrub_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!scrub_any && scrub_vec[i]) begin
                scrub_any = 1'b1;
                scrub_way = WAY_W'(i);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_WAYS; j++) begin
            age_d[j] = age_q[j];
            if (touch_en) begin
                if (WAY_W'(j) == touch_way) begin
                    age_d[j] = '0;
                end else if (age_q[j] < age_q[touch_way]) begin
                    age_d[j] = age_q[j] + WAY_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_way_d     = mem_way_q;
        idle_cnt_d    = idle_cnt_q;
        touch_en      = 1'b0;
        touch_way     = victim;
        vc_ack        = 1'b0;
        vc_miss       = 1'b0;
        busy          = 1'b0;
        load_data     = 1'b0;
        load_dirty    = 1'b0;
        dirty_in      = 1'b0;
        data_way      = victim;
        mem_write_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (l2_write || l2_read) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q < 8'(IDLE_THRESH)) begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
                if (l2_write) begin
                    if (hit) begin
                        vc_ack     = 1'b1;
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        data_way   = hit_way;
                        dirty_in   = dirty_vec[hit_way] | l2_dirty;
                        touch_en   = 1'b1;
                        touch_way  = hit_way;
                    end else if (!(valid_vec[victim] && dirty_vec[victim])) begin
                        vc_ack     = 1'b1;
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = l2_dirty;
                        touch_en   = 1'b1;
                    end else begin
                        // Request stays held and is retried as a clean fill after write-back.
                        mem_way_d = victim;
                        state_d   = StDemandWb;
                    end
                end else if (l2_read) begin
                    if (hit) begin
                        vc_ack    = 1'b1;
                        data_way  = hit_way;
                        touch_en  = 1'b1;
                        touch_way = hit_way;
                    end else begin
                        vc_miss = 1'b1;
                    end
                end else if (idle_cnt_q == 8'(IDLE_THRESH) && scrub_any) begin
                    mem_way_d = scrub_way;
                    state_d   = StScrubWb;
                end
            end
            StDemandWb, StScrubWb: begin
                idle_cnt_d    = '0;
                busy          = 1'b1;
                mem_write_req = 1'b1;
                data_way      = mem_way_q;
                if (mem_ack) begin
                    load_dirty = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mem_way_q  <= '0;
            idle_cnt_q <= '0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                age_q[i] <= WAY_W'(i);
            end
        end else begin
            state_q    <= state_d;
            mem_way_q  <= mem_way_d;
            idle_cnt_q <= idle_cnt_d;
            for (int i = 0; i < NUM_WAYS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_vc_ctrl_param.sv
// Directed bench for vc_ctrl_param in a 4-way, IDLE_THRESH=4 configuration.
// The bench plays the datapath role, presenting valid/dirty/hit as the stores would leave them.
module tb_vc_ctrl_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       l2_read, l2_write, l2_dirty, hit, mem_ack;
    logic [1:0] hit_way;
    logic [3:0] valid_vec, dirty_vec;
    logic       vc_ack, vc_miss, busy, load_data, load_dirty, dirty_in, mem_write_req;
    logic [1:0] data_way, mem_way, lru_way;

    int checks   = 0;
    int failures = 0;

    // Flag order: ack, miss, busy, load_data, load_dirty, dirty_in, mem_write_req, data_way
    logic [8:0] obs;
    assign obs = {vc_ack, vc_miss, busy, load_data, load_dirty, dirty_in, mem_write_req, data_way};

    always #5 clk = ~clk;

    vc_ctrl_param #(.NUM_WAYS(4), .IDLE_THRESH(4)) dut (
        .clk(clk), .rst_n(rst_n), .l2_read(l2_read), .l2_write(l2_write), .l2_dirty(l2_dirty),
        .hit(hit), .hit_way(hit_way), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .mem_ack(mem_ack), .vc_ack(vc_ack), .vc_miss(vc_miss), .busy(busy),
        .load_data(load_data), .load_dirty(load_dirty), .dirty_in(dirty_in),
        .data_way(data_way), .mem_write_req(mem_write_req), .mem_way(mem_way), .lru_way(lru_way)
    );

    task automatic test_reset();
        rst_n = 1'b0; l2_read = 0; l2_write = 0; l2_dirty = 0; hit = 0; hit_way = 0;
        valid_vec = 4'b0000; dirty_vec = 4'b0000; mem_ack = 0;
        #3;
        checks++;
        if (obs !== 9'b0000000_00) begin
            failures++; $display("FAIL reset_outputs: got %b want %b", obs, 9'b0000000_00);
        end
        checks++;
        if ({lru_way, mem_way} !== 4'b0000) begin
            failures++; $display("FAIL reset_ways: got lru=%0d mem=%0d want 0 0", lru_way, mem_way);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_fill();
        @(negedge clk); l2_write = 1; l2_dirty = 1; hit = 0; #1;
        checks++;
        if (obs !== {7'b1001110, 2'd0}) begin
            failures++; $display("FAIL fill_invalid0: got %b want %b", obs, {7'b1001110, 2'd0});
        end
        @(negedge clk); l2_write = 0; valid_vec = 4'b0001; dirty_vec = 4'b0001; #1;
        checks++;
        if (obs !== {7'b0000000, 2'd1} || lru_way !== 2'd1) begin
            failures++; $display("FAIL fill_next_lru: got %b lru=%0d want data_way=1 lru=1", obs, lru_way);
        end
        @(negedge clk); l2_write = 1; l2_dirty = 0; #1;
        checks++;
        if (obs !== {7'b1001100, 2'd1}) begin
            failures++; $display("FAIL fill_way1: got %b want %b", obs, {7'b1001100, 2'd1});
        end
        @(negedge clk); valid_vec = 4'b0011; #1;
        checks++;
        if (obs !== {7'b1001100, 2'd2}) begin
            failures++; $display("FAIL fill_way2: got %b want %b", obs, {7'b1001100, 2'd2});
        end
        @(negedge clk); valid_vec = 4'b0111; l2_dirty = 1; #1;
        checks++;
        if (obs !== {7'b1001110, 2'd3}) begin
            failures++; $display("FAIL fill_way3: got %b want %b", obs, {7'b1001110, 2'd3});
        end
        // ages now {3,2,1,0}: way 0 is the oldest
        @(negedge clk); l2_write = 0; valid_vec = 4'b1111; dirty_vec = 4'b1001; #1;
        checks++;
        if (lru_way !== 2'd0) begin
            failures++; $display("FAIL fill_all_valid_lru: got %0d want 0", lru_way);
        end
    endtask

    task automatic test_hit();
        @(negedge clk); l2_write = 1; hit = 1; hit_way = 2; l2_dirty = 0; #1;
        checks++;
        if (obs !== {7'b1001100, 2'd2}) begin
            failures++; $display("FAIL write_hit_clean: got %b want %b", obs, {7'b1001100, 2'd2});
        end
        @(negedge clk); hit_way = 0; #1;
        checks++;
        if (obs !== {7'b1001110, 2'd0}) begin
            failures++; $display("FAIL write_hit_keep_dirty: got %b want %b", obs, {7'b1001110, 2'd0});
        end
        @(negedge clk); l2_write = 0; l2_read = 1; hit_way = 1; #1;
        checks++;
        if (obs !== {7'b1000000, 2'd1}) begin
            failures++; $display("FAIL read_hit: got %b want %b", obs, {7'b1000000, 2'd1});
        end
        // ages {1,0,2,3} after the three touches
        @(negedge clk); l2_read = 0; hit = 0; #1;
        checks++;
        if (obs !== {7'b0000000, 2'd3} || lru_way !== 2'd3) begin
            failures++; $display("FAIL hit_lru_update: got %b lru=%0d want lru=3", obs, lru_way);
        end
    endtask

    task automatic test_demand_wb();
        @(negedge clk); l2_write = 1; l2_dirty = 0; #1;
        checks++;
        if (obs !== {7'b0000000, 2'd3}) begin
            failures++; $display("FAIL dirty_miss_no_ack: got %b want %b", obs, {7'b0000000, 2'd3});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== {7'b0010001, 2'd3} || mem_way !== 2'd3) begin
                failures++; $display("FAIL demand_wb_wait%0d: got %b mem_way=%0d want %b mem_way=3",
                                     k, obs, mem_way, {7'b0010001, 2'd3});
            end
        end
        @(negedge clk); mem_ack = 1; #1;
        checks++;
        if (obs !== {7'b0010101, 2'd3}) begin
            failures++; $display("FAIL demand_wb_ack: got %b want %b", obs, {7'b0010101, 2'd3});
        end
        @(negedge clk); mem_ack = 0; dirty_vec = 4'b0001; #1;
        checks++;
        if (obs !== {7'b1001100, 2'd3}) begin
            failures++; $display("FAIL demand_refill: got %b want %b", obs, {7'b1001100, 2'd3});
        end
        @(negedge clk); l2_write = 0; mem_ack = 1; #1;
        checks++;
        if (lru_way !== 2'd2) begin
            failures++; $display("FAIL refill_lru: got %0d want 2", lru_way);
        end
        @(negedge clk); mem_ack = 0; #1;
        checks++;
        if (obs !== {7'b0000000, 2'd2}) begin
            failures++; $display("FAIL idle_mem_ack_ignored: got %b want %b", obs, {7'b0000000, 2'd2});
        end
    endtask

    task automatic test_read_miss();
        @(negedge clk); l2_read = 1; hit = 0; #1;
        checks++;
        if (obs !== {7'b0100000, 2'd2}) begin
            failures++; $display("FAIL read_miss: got %b want %b", obs, {7'b0100000, 2'd2});
        end
        @(negedge clk); l2_read = 0; #1;
        checks++;
        if (obs !== {7'b0000000, 2'd2}) begin
            failures++; $display("FAIL read_miss_one_cycle: got %b want %b", obs, {7'b0000000, 2'd2});
        end
        @(negedge clk); l2_read = 1; l2_write = 1; hit = 1; hit_way = 2; l2_dirty = 1; #1;
        checks++;
        if (obs !== {7'b1001110, 2'd2}) begin
            failures++; $display("FAIL write_beats_read: got %b want %b", obs, {7'b1001110, 2'd2});
        end
        @(negedge clk); l2_read = 0; l2_write = 0; hit = 0; l2_dirty = 0;
    endtask

    task automatic test_scrub();
        rst_n = 1'b0; valid_vec = 4'b1111; dirty_vec = 4'b0110;
        @(negedge clk); rst_n = 1'b1; #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
            end
            checks++;
            if (obs !== {7'b0000000, 2'd3}) begin
                failures++; $display("FAIL scrub_idle%0d: got %b want %b", k, obs, {7'b0000000, 2'd3});
            end
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== {7'b0010001, 2'd1} || mem_way !== 2'd1) begin
            failures++; $display("FAIL scrub_start: got %b mem_way=%0d want %b mem_way=1",
                                 obs, mem_way, {7'b0010001, 2'd1});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); l2_write = 1; hit = 0; l2_dirty = 0; #1;
            checks++;
            if (obs !== {7'b0010001, 2'd1}) begin
                failures++; $display("FAIL scrub_hold_write%0d: got %b want %b", k, obs, {7'b0010001, 2'd1});
            end
        end
        @(negedge clk); mem_ack = 1; #1;
        checks++;
        if (obs !== {7'b0010101, 2'd1}) begin
            failures++; $display("FAIL scrub_ack: got %b want %b", obs, {7'b0010101, 2'd1});
        end
        @(negedge clk); mem_ack = 0; dirty_vec = 4'b0100; #1;
        checks++;
        if (obs !== {7'b1001100, 2'd3}) begin
            failures++; $display("FAIL scrub_held_write: got %b want %b", obs, {7'b1001100, 2'd3});
        end
        @(negedge clk); l2_write = 0; #1;
        checks++;
        if (lru_way !== 2'd2) begin
            failures++; $display("FAIL scrub_lru: got %0d want 2", lru_way);
        end
    endtask

    task automatic test_reset_mid_wb();
        @(negedge clk); l2_write = 1; hit = 0; #1;
        @(negedge clk); #1;
        checks++;
        if (obs !== {7'b0010001, 2'd2}) begin
            failures++; $display("FAIL rst_wb_entered: got %b want %b", obs, {7'b0010001, 2'd2});
        end
        #2; rst_n = 1'b0; l2_write = 0; #1;
        checks++;
        if (obs !== {7'b0000000, 2'd3} || mem_way !== 2'd0) begin
            failures++; $display("FAIL rst_async_drop: got %b mem_way=%0d want %b mem_way=0",
                                 obs, mem_way, {7'b0000000, 2'd3});
        end
        @(negedge clk); rst_n = 1'b1; #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++; $display("FAIL rst_idle_cnt%0d: got busy=%b want 0", k, busy);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== {7'b0010001, 2'd2} || mem_way !== 2'd2) begin
            failures++; $display("FAIL rst_rescrub: got %b mem_way=%0d want %b mem_way=2",
                                 obs, mem_way, {7'b0010001, 2'd2});
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_demand_wb();
        test_read_miss();
        test_scrub();
        test_reset_mid_wb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_ctrl_param.md
Name: vc_ctrl_param

Overview:
- Parametrised victim-cache controller between L2 and physical memory; successor to the fixed 8-way VC controller.
- Adds a configurable way count, an internal age-based LRU, read-miss signalling and idle-time background scrubbing of dirty entries.
- Drives datapath load/index strobes only; tag/data/dirty arrays and hit detection live in the VC datapath.

Parameters:
NUM_WAYS, 8, number of VC ways (power of 2, 2..16)
WAY_W, $clog2(NUM_WAYS), way index width
IDLE_THRESH, 4, consecutive idle cycles before a background scrub may start (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
l2_read  in  1  L2 read request (level, held until vc_ack or vc_miss)
l2_write  in  1  L2 victim write request (level, held until vc_ack)
l2_dirty  in  1  dirty bit of the incoming L2 victim
hit  in  1  datapath tag match for the current request
hit_way  in  WAY_W  matching way
valid_vec  in  NUM_WAYS  per-way valid bits
dirty_vec  in  NUM_WAYS  per-way dirty bits
mem_ack  in  1  memory write-back complete
vc_ack  out  1  request completed this cycle
vc_miss  out  1  read miss, one-cycle pulse
busy  out  1  controller in a write-back state
load_data  out  1  write data/tag into data_way
load_dirty  out  1  write dirty_in into data_way (or mem_way in write-back states)
dirty_in  out  1  dirty value to store
data_way  out  WAY_W  way index for datapath access
mem_write_req  out  1  memory write request (level, held until mem_ack)
mem_way  out  WAY_W  way being written back (registered)
lru_way  out  WAY_W  current replacement victim

Behaviour:
- States: IDLE, DEMAND_WB, SCRUB_WB. Reset: state=IDLE, idle_cnt=0, mem_way=0, age[i]=i.
- Outputs are combinational in IDLE; with no request, all 1-bit outputs are 0 and data_way=lru_way.
- Victim selection: the lowest-index invalid way if any exists, else the way with maximum age.
- Touch(w): age[w]<=0; every age[j]<age[w] increments. This is applied on every ack'd hit or fill.
- IDLE, l2_write and l2_read together: the write wins; the read waits.
- IDLE write, hit: same cycle vc_ack, load_data, load_dirty, data_way=hit_way, dirty_in=dirty_vec[hit_way]|l2_dirty, touch(hit_way).
- IDLE write, miss, victim invalid or clean: same cycle vc_ack, load_data, load_dirty, data_way=lru_way, dirty_in=l2_dirty, touch(victim).
- IDLE write, miss, victim valid and dirty: no ack. mem_way<=lru_way, next state DEMAND_WB. The held request completes as a clean-victim fill in the first IDLE cycle after the write-back.
- IDLE read, hit: vc_ack, data_way=hit_way, touch. No load and no dirty change.
- IDLE read, miss: vc_miss=1 for exactly one cycle, no ack. L2 must drop l2_read the next cycle.
- DEMAND_WB / SCRUB_WB: busy=1, mem_write_req=1, data_way=mem_way.
  - On mem_ack: load_dirty=1, dirty_in=0 for mem_way, next state IDLE.
  - The LRU does not change.
  - L2 requests are neither ack'd nor missed in these states.
- idle_cnt:
  - Increments in IDLE when there is no l2 request; saturates at IDLE_THRESH.
  - Clears on any request and in the write-back states.
- Scrub: in IDLE with no request, idle_cnt==IDLE_THRESH and any (valid_vec&dirty_vec) set: mem_way<=lowest such index, next state SCRUB_WB.
  - A request arriving on the same cycle takes priority over the scrub.
- mem_ack outside the write-back states is ignored.
- Reset asserted mid-write-back: mem_write_req drops asynchronously and state returns to IDLE. The dirty bit stays set, so the entry is rescrubbed later.
- Latency: hit or clean fill is 0 cycles (same-cycle ack). Dirty-miss fill takes memory latency + 1 cycle.

Test Plan:
- Reset, then 4-way config, write miss, all invalid, l2_dirty=1 -> same-cycle vc_ack, data_way=0, dirty_in=1. Next lru_way=1.
- Write hit way 2 (dirty_vec[2]=0, l2_dirty=0) -> vc_ack, dirty_in=0, age[2]=0. lru_way moves to the oldest remaining way.
- All valid, victim way 3 dirty, write miss -> mem_write_req, mem_way=3, busy. mem_ack after 5 cycles -> dirty cleared, then ack'd fill into way 3 on the next cycle.
- Read miss -> vc_miss high for exactly 1 cycle, vc_ack 0, no load strobes.
- No requests, dirty_vec=4'b0110, IDLE_THRESH=4 -> SCRUB_WB entered after 4 idle cycles with mem_way=1. l2_write arriving mid-scrub is held until mem_ack, then serviced.
- Deassert rst_n during DEMAND_WB -> mem_write_req=0 immediately; state IDLE, idle_cnt=0 after release.
